instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  IF stage of the RV32IM pipeline. Holds the PC and issues reads to instruction memory, honouring the memory's busy-wait.
//  Owns the IF/ID pipeline register that feeds the decode/control stage: INSTRUCTION_ID, PC_ID, PC_PLUS4_ID, VALID_ID.
//  Takes STALL from the hazard unit and BRANCH_TAKEN/BRANCH_TARGET redirects from EX.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  PC_INCR    4              sequential PC increment, in bytes
// PORTS
//  CLK             in   1   clock; all state updates on the rising edge
//  RESET           in   1   synchronous, active-low reset (0 = reset)
//  STALL           in   1   hazard unit: hold the IF/ID register and PC
//  BRANCH_TAKEN    in   1   EX redirect strobe; highest priority after RESET
//  BRANCH_TARGET   in   32  redirect address; bits [1:0] are forced to 0
//  IMEM_ADDR       out  32  instruction memory read address
//  IMEM_READ       out  1   instruction memory read request
//  IMEM_READDATA   in   32  instruction word; valid when IMEM_READ=1 and IMEM_BUSY_WAIT=0
//  IMEM_BUSY_WAIT  in   1   memory not yet complete
//  FETCH_BUSY      out  1   IMEM_READ & IMEM_BUSY_WAIT (to the hazard unit)
//  INSTRUCTION_ID  out  32  IF/ID instruction; NOP (32'h0000_0013) when invalid
//  PC_ID           out  32  IF/ID PC
//  PC_PLUS4_ID     out  32  IF/ID PC+PC_INCR (JAL/JALR link value)
//  VALID_ID        out  1   IF/ID slot holds a real instruction
// BEHAVIOUR
//  FSM states:
//   - FETCH: request PC.
//   - HOLD: word captured while STALL is high; no request.
//   - DISCARD: an access is in flight but was made stale by a redirect.
//  Reset (RESET=0 at an edge), applied regardless of any other input:
//   - PC<=RESET_PC, state<=FETCH, VALID_ID<=0, INSTRUCTION_ID<=NOP.
//   - PC_ID<=0, PC_PLUS4_ID<=0; hold and discard registers cleared.
//   - IMEM_READ=0 while RESET=0. An access in flight at reset is abandoned.
//  Request side:
//   - IMEM_READ=1 in FETCH and DISCARD; 0 in HOLD.
//   - IMEM_ADDR=PC in FETCH and HOLD; in DISCARD it is the stale address latched at redirect.
//   - IMEM_ADDR is stable for the whole access.
//  Completion is the cycle with IMEM_READ=1 and IMEM_BUSY_WAIT=0. Zero-wait memory gives 1 instruction/cycle.
//  Latency: PC presented in cycle N with no wait -> INSTRUCTION_ID/VALID_ID visible in cycle N+1.
//  FETCH:
//   - complete & !STALL: IF/ID<={PC,PC+PC_INCR,data}, VALID_ID<=1, PC<=PC+PC_INCR.
//   - complete & STALL: data->hold register, state<=HOLD; IF/ID and PC unchanged.
//   - busy & !STALL: VALID_ID<=0, INSTRUCTION_ID<=NOP (bubble).
//   - busy & STALL: IF/ID unchanged.
//  HOLD: !STALL -> IF/ID<=hold register, VALID_ID<=1, PC<=PC+PC_INCR, state<=FETCH.
//  DISCARD: on completion the data is dropped and state<=FETCH; the new PC is fetched next cycle.
//  BRANCH_TAKEN=1, which overrides STALL and completion:
//   - PC<={BRANCH_TARGET[31:2],2'b00}, VALID_ID<=0, INSTRUCTION_ID<=NOP.
//   - Any HOLD word is dropped.
//   - Next state: DISCARD if an access is in flight (IMEM_READ & IMEM_BUSY_WAIT), else FETCH.
//   - A branch during DISCARD updates PC and stays in DISCARD.
//  PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
// CONFIGURATION
//  Macro IFU_PERF_CNT_EN, when defined, adds two outputs:
//   - FETCH_COUNT out 32: increments on each IF/ID load with VALID_ID<=1.
//   - BUBBLE_COUNT out 32: increments on each cycle VALID_ID<=0 is loaded outside reset.
//   - Both counters clear on reset and wrap modulo 2^32.
//  When undefined, the ports and counters are absent and behaviour is otherwise identical.
// STRUCTURE
//  rv32_pkg: NOP_INSTR=32'h0000_0013, XLEN=32, ifu_state_t {FETCH,HOLD,DISCARD}.
//  Sub-module if_id_pipeline_reg: load/flush/hold register for {PC,PC+4,INSTR,VALID}.
//  The FSM and PC logic stay in instruction_fetch_unit.
// TESTING
//  1. Reset, zero-wait memory returning 32'h00A00093, 32'h00108113:
//     - PC_ID 0 then 4; VALID_ID=1 from cycle 1.
//     - PC_PLUS4_ID 4 then 8.
//  2. IMEM_BUSY_WAIT high 3 cycles for addr 8:
//     - IMEM_ADDR stays 8; VALID_ID=0 (NOP) for 3 cycles; FETCH_BUSY=1.
//     - Then INSTRUCTION_ID=data with PC_ID=8.
//  3. STALL=1 while the access to 0xC completes:
//     - IF/ID held; IMEM_READ=0 in HOLD.
//     - On STALL release, PC_ID=0xC with the held word; next request is 0x10.
//  4. BRANCH_TAKEN with target 0x103 during a busy access to 0x20:
//     - IMEM_ADDR stays 0x20 until done and that word is dropped.
//     - Next fetch is 0x100; VALID_ID=0 in between.
//  5. RESET=0 mid-access and mid-STALL:
//     - Next cycle IMEM_READ=0, VALID_ID=0, INSTRUCTION_ID=NOP.
//     - Fetch resumes at RESET_PC.
//  6. Branch to 0xFFFFFFFC, zero-wait: PC_ID=0xFFFFFFFC then 0x0. With IFU_PERF_CNT_EN, FETCH_COUNT matches valid loads.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: datapath width, the canonical NOP and the IF stage states.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register: load a fetched word, flush to an invalid NOP, or hold.
// reset_n is synchronous and active-low; load wins over flush.
module if_id_pipeline_reg
  import rv32_pkg::*;
#(
  parameter int PC_INCR = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic [XLEN-1:0] instr_id,
  output logic            valid_id
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_id       <= '0;
      pc_plus4_id <= '0;
      instr_id    <= NOP_INSTR;
      valid_id    <= 1'b0;
    end else if (load) begin
      pc_id       <= pc;
      pc_plus4_id <= pc + XLEN'(PC_INCR);
      instr_id    <= instr;
      valid_id    <= 1'b1;
    end else if (flush) begin
      // PC fields keep their last value; only the slot is invalidated
      instr_id    <= NOP_INSTR;
      valid_id    <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32IM instruction fetch stage: PC, memory request FSM and IF/ID register.
// Optional macro IFU_PERF_CNT_EN adds FETCH_COUNT / BUBBLE_COUNT outputs.
module instruction_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_INCR  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSY_WAIT,
  output logic        FETCH_BUSY,
  output logic [31:0] INSTRUCTION_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] PC_PLUS4_ID,
  output logic        VALID_ID
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] BUBBLE_COUNT
`endif
);

  ifu_state_t      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] hold_reg, hold_next;
  logic [XLEN-1:0] stale_reg, stale_next;
  logic [XLEN-1:0] load_instr;
  logic            load, flush;
  logic            complete, in_flight;

  assign IMEM_READ  = RESET && (state_reg != HOLD);
  assign IMEM_ADDR  = (state_reg == DISCARD) ? stale_reg : pc_reg;
  assign FETCH_BUSY = IMEM_READ && IMEM_BUSY_WAIT;
  assign complete   = IMEM_READ && !IMEM_BUSY_WAIT;
  assign in_flight  = FETCH_BUSY;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    hold_next  = hold_reg;
    stale_next = stale_reg;
    load       = 1'b0;
    flush      = 1'b0;
    load_instr = IMEM_READDATA;
    if (BRANCH_TAKEN) begin
      // A redirect beats stall and completion; an in-flight access must still be drained
      pc_next    = {BRANCH_TARGET[31:2], 2'b00};
      flush      = 1'b1;
      hold_next  = '0;
      state_next = in_flight ? DISCARD : FETCH;
      if (in_flight) stale_next = IMEM_ADDR;
    end else begin
      unique case (state_reg)
        FETCH: begin
          if (complete && !STALL) begin
            load    = 1'b1;
            pc_next = pc_reg + XLEN'(PC_INCR);
          end else if (complete) begin
            hold_next  = IMEM_READDATA;
            state_next = HOLD;
          end else if (!STALL) begin
            flush = 1'b1;
          end
        end
        HOLD: begin
          if (!STALL) begin
            load       = 1'b1;
            load_instr = hold_reg;
            pc_next    = pc_reg + XLEN'(PC_INCR);
            state_next = FETCH;
          end
        end
        DISCARD: begin
          flush = !STALL;
          if (complete) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      hold_reg  <= '0;
      stale_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      hold_reg  <= hold_next;
      stale_reg <= stale_next;
    end
  end

  if_id_pipeline_reg #(
    .PC_INCR (PC_INCR)
  ) u_if_id (
    .clk         (CLK),
    .reset_n     (RESET),
    .load        (load),
    .flush       (flush),
    .pc          (pc_reg),
    .instr       (load_instr),
    .pc_id       (PC_ID),
    .pc_plus4_id (PC_PLUS4_ID),
    .instr_id    (INSTRUCTION_ID),
    .valid_id    (VALID_ID)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_reg, bubble_count_reg;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      fetch_count_reg  <= '0;
      bubble_count_reg <= '0;
    end else begin
      if (load)  fetch_count_reg  <= fetch_count_reg + 32'd1;
      if (flush) bubble_count_reg <= bubble_count_reg + 32'd1;
    end
  end

  assign FETCH_COUNT  = fetch_count_reg;
  assign BUBBLE_COUNT = bubble_count_reg;
`endif

endmodule
